// File: rtl/mult_share_arbiter_if.sv
// Client/multiplier-side bus of the shared multiplier arbiter.
interface mult_share_arbiter_if #(
  parameter int unsigned SIZE = 8,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*SIZE-1:0] req_a;
  logic [NREQ*SIZE-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic [SIZE-1:0]      mul_a;
  logic [SIZE-1:0]      mul_b;
  logic [2*SIZE-1:0]    mul_y;
  logic [NREQ-1:0]      rsp_valid;
  logic [2*SIZE-1:0]    rsp_y;
  logic                 idle;

  // Environment side: clients plus the multiplier instance.
  modport master (
    output req_valid, req_a, req_b, mul_y,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_y, idle
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, mul_y,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_y, idle
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters,
// with a requester-ID tag pipeline that returns each product to its owner.
module mult_share_arbiter #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arbiter_if.slave  bus
);

  // Stage 0 sits beside the mul_a/mul_b register; the remaining LATENCY
  // stages mirror the multiplier, so the last stage lines up with mul_y.
  localparam int unsigned TAGS = LATENCY + 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [SIZE-1:0] mul_a_q, mul_a_d;
  logic [SIZE-1:0] mul_b_q, mul_b_d;
  tag_t            tag_q [TAGS];
  tag_t            tag_d [TAGS];

  logic            gnt_any_c;
  logic [IDW-1:0]  gnt_id_c;
  logic            tag_busy_c;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_any_c = 1'b0;
    gnt_id_c  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(ptr_q) + off) % NREQ;
      if (!gnt_any_c && bus.req_valid[IDW'(idx)]) begin
        gnt_any_c = 1'b1;
        gnt_id_c  = IDW'(idx);
      end
    end
    if (rst) begin
      gnt_any_c = 1'b0;
    end
  end

  // Next state: issue the granted operands (or a 0*0 bubble) and shift tags.
  always_comb begin
    ptr_d   = ptr_q;
    mul_a_d = '0;
    mul_b_d = '0;
    for (int unsigned i = 0; i < TAGS; i++) begin
      tag_d[i] = '0;
    end
    tag_d[0].vld = gnt_any_c;
    tag_d[0].id  = gnt_id_c;
    for (int unsigned i = 1; i < TAGS; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (gnt_any_c) begin
      ptr_d   = gnt_id_c;
      mul_a_d = bus.req_a[32'(gnt_id_c)*SIZE +: SIZE];
      mul_b_d = bus.req_b[32'(gnt_id_c)*SIZE +: SIZE];
    end
  end

  // State registers; reset drops all in-flight tags and re-arms requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= IDW'(NREQ - 1);
      mul_a_q <= '0;
      mul_b_q <= '0;
      for (int unsigned i = 0; i < TAGS; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      for (int unsigned i = 0; i < TAGS; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Grant, response routing and idle status.
  always_comb begin
    tag_busy_c = 1'b0;
    for (int unsigned i = 0; i < TAGS; i++) begin
      tag_busy_c = tag_busy_c | tag_q[i].vld;
    end
    bus.req_ready = '0;
    if (gnt_any_c) begin
      bus.req_ready = NREQ'(1) << gnt_id_c;
    end
    bus.rsp_valid = '0;
    bus.rsp_y     = '0;
    if (tag_q[TAGS-1].vld) begin
      bus.rsp_valid = NREQ'(1) << tag_q[TAGS-1].id;
      bus.rsp_y     = bus.mul_y;
    end
    bus.idle = rst | (~|bus.req_valid & ~tag_busy_c);
  end

  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin choice + queue of due responses).
module tb_mult_share_arbiter;
  localparam int unsigned SIZE    = 8;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned IDW     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult_share_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

  mult_share_arbiter #(
    .SIZE(SIZE), .NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Multiplier instance model: LATENCY register stages, no stall.
  logic [2*SIZE-1:0] mpipe [LATENCY] = '{default: '0};
  always @(posedge clk) begin
    mpipe[0] <= (2*SIZE)'(bus.mul_a) * (2*SIZE)'(bus.mul_b);
    for (int i = 1; i < int'(LATENCY); i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_y = mpipe[LATENCY-1];

  typedef struct {
    int due;
    int id;
    int prod;
  } exp_t;

  exp_t            q[$];
  int              m_ptr = NREQ - 1;
  logic [SIZE-1:0] m_mula = '0, m_mulb = '0;
  bit              seq_ok = 1'b0;
  int              cyc = 0;

  logic            pend_v [NREQ];
  logic [SIZE-1:0] pend_a [NREQ];
  logic [SIZE-1:0] pend_b [NREQ];
  logic [NREQ-1:0] refill = '0;
  logic [NREQ-1:0] drop_mask = '0;

  logic [NREQ-1:0]   last_rdy, last_rspv;
  logic [2*SIZE-1:0] last_rspy;
  logic [SIZE-1:0]   last_mula;
  logic              last_idle;
  int                n_pulses = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int off = 1; off <= int'(NREQ); off++) begin
      if (v[(ptr + off) % int'(NREQ)]) return (ptr + off) % int'(NREQ);
    end
    return -1;
  endfunction

  // One clock cycle: drive clients, check every output, advance the model.
  task automatic run_cycle(input bit r);
    logic [NREQ-1:0]      v;
    logic [NREQ*SIZE-1:0] a, b;
    logic [NREQ-1:0]      exp_rsp;
    logic [2*SIZE-1:0]    exp_y;
    int                   g;
    @(negedge clk);
    for (int i = 0; i < int'(NREQ); i++) begin
      v[i] = pend_v[i] & ~drop_mask[i];
      a[i*SIZE +: SIZE] = pend_a[i];
      b[i*SIZE +: SIZE] = pend_b[i];
    end
    rst = r;
    bus.req_valid = v;
    bus.req_a = a;
    bus.req_b = b;
    #1;
    g = r ? -1 : model_grant(v, m_ptr);
    check("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    check("idle", 32'(bus.idle), 32'(r || (v == '0 && q.size() == 0)));
    exp_rsp = '0;
    exp_y   = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rsp = NREQ'(1) << q[0].id;
      exp_y   = (2*SIZE)'(q[0].prod);
      void'(q.pop_front());
    end
    if (seq_ok) begin
      check("mul_a", 32'(bus.mul_a), 32'(m_mula));
      check("mul_b", 32'(bus.mul_b), 32'(m_mulb));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
      check("rsp_y", 32'(bus.rsp_y), 32'(exp_y));
      if (bus.rsp_valid != '0) n_pulses++;
    end
    last_rdy  = bus.req_ready;
    last_rspv = bus.rsp_valid;
    last_rspy = bus.rsp_y;
    last_mula = bus.mul_a;
    last_idle = bus.idle;
    if (r) begin
      q.delete();
      m_ptr  = NREQ - 1;
      m_mula = '0;
      m_mulb = '0;
      seq_ok = 1'b1;
    end else if (g >= 0) begin
      m_ptr = g;
      q.push_back('{cyc + 1 + int'(LATENCY), g, int'(pend_a[g]) * int'(pend_b[g])});
      m_mula = pend_a[g];
      m_mulb = pend_b[g];
      if (refill[g]) begin
        pend_a[g] = SIZE'($urandom);
        pend_b[g] = SIZE'($urandom);
      end else begin
        pend_v[g] = 1'b0;
      end
    end else begin
      m_mula = '0;
      m_mulb = '0;
    end
    drop_mask = '0;
    cyc++;
  endtask

  task automatic set_req(input int id, input int a, input int b);
    pend_v[id] = 1'b1;
    pend_a[id] = SIZE'(a);
    pend_b[id] = SIZE'(b);
  endtask

  task automatic do_reset();
    run_cycle(1'b1);
    run_cycle(1'b1);
  endtask

  initial begin
    int prods [4];
    prods = '{2, 12, 30, 56};
    for (int i = 0; i < int'(NREQ); i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // Single request 3*4 from requester 0.
    do_reset();
    check("rst_idle", 32'(last_idle), 32'd1);
    check("rst_ready", 32'(last_rdy), 32'd0);
    set_req(0, 3, 4);
    run_cycle(1'b0);
    check("t1_grant", 32'(last_rdy), 32'h1);
    repeat (4) run_cycle(1'b0);
    check("t1_rsp_valid", 32'(last_rspv), 32'h1);
    check("t1_rsp_y", 32'(last_rspy), 32'd12);

    // All four requesters together: strict order, back-to-back responses.
    do_reset();
    set_req(0, 1, 2); set_req(1, 3, 4); set_req(2, 5, 6); set_req(3, 7, 8);
    for (int n = 0; n < 4; n++) begin
      run_cycle(1'b0);
      check("t2_grant", 32'(last_rdy), 32'd1 << n);
    end
    for (int n = 0; n < 4; n++) begin
      run_cycle(1'b0);
      check("t2_rsp_valid", 32'(last_rspv), 32'd1 << n);
      check("t2_rsp_y", 32'(last_rspy), 32'(prods[n]));
    end

    // Requesters 1 and 3 continuously valid: alternate every cycle.
    do_reset();
    refill = 4'b1010;
    set_req(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    set_req(3, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    for (int n = 0; n < 8; n++) begin
      run_cycle(1'b0);
      check("t3_grant", 32'(last_rdy), (n % 2 == 0) ? 32'h2 : 32'h8);
    end
    refill = '0;
    pend_v[1] = 1'b0;
    pend_v[3] = 1'b0;
    repeat (6) run_cycle(1'b0);

    // Largest operands.
    set_req(2, 255, 255);
    run_cycle(1'b0);
    check("t4_grant", 32'(last_rdy), 32'h4);
    repeat (4) run_cycle(1'b0);
    check("t4_rsp_valid", 32'(last_rspv), 32'h4);
    check("t4_rsp_y", 32'(last_rspy), 32'd65025);

    // Reset with three operations in flight.
    do_reset();
    set_req(0, 9, 9); set_req(1, 10, 10); set_req(2, 11, 11);
    repeat (3) run_cycle(1'b0);
    n_pulses = 0;
    run_cycle(1'b1);
    repeat (6) run_cycle(1'b0);
    check("t5_no_pulses", 32'(n_pulses), 32'd0);
    check("t5_idle", 32'(last_idle), 32'd1);
    set_req(3, 2, 2); set_req(0, 5, 5);
    run_cycle(1'b0);
    check("t5_first_grant", 32'(last_rdy), 32'h1);
    run_cycle(1'b0);
    check("t5_second_grant", 32'(last_rdy), 32'h8);

    // Requester 0 withdraws in the cycle it would win.
    do_reset();
    set_req(0, 6, 7); set_req(1, 8, 9);
    drop_mask = 4'b0001;
    run_cycle(1'b0);
    check("t6_drop_grant", 32'(last_rdy), 32'h2);
    run_cycle(1'b0);
    check("t6_next_grant", 32'(last_rdy), 32'h1);

    // Quiet period: pipe drains and the block reports idle.
    repeat (6) run_cycle(1'b0);
    check("t7_mul_a", 32'(last_mula), 32'd0);
    check("t7_rsp_valid", 32'(last_rspv), 32'd0);
    check("t7_idle", 32'(last_idle), 32'd1);

    // Randomized traffic with occasional withdrawals and resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
      if ($urandom_range(0, 19) == 0) drop_mask = NREQ'($urandom);
      run_cycle($urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < int'(NREQ); i++) pend_v[i] = 1'b0;
    repeat (8) run_cycle(1'b0);
    check("final_idle", 32'(last_idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
